pc_fetch_unit: RTL



---
 rtl/pc_fetch_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, runs the instruction-memory request/ack handshake
// and hands each instruction plus its PC to decode over valid/ready.
module pc_fetch_unit #(
  parameter int                          ADDR_WIDTH = 8,
  parameter int                          DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]       RESET_PC   = '0
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  input  logic                  in_pc_sel,
  input  logic [ADDR_WIDTH-1:0] in_target,
  output logic                  out_imem_req,
  output logic [ADDR_WIDTH-1:0] out_imem_addr,
  input  logic                  in_imem_ack,
  input  logic [DATA_WIDTH-1:0] in_imem_data,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  logic [1:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic                  req_reg, req_next;
  logic                  valid_reg, valid_next;
  logic [DATA_WIDTH-1:0] instr_reg, instr_next;
  logic [ADDR_WIDTH-1:0] out_pc_reg, out_pc_next;

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    req_next    = req_reg;
    valid_next  = valid_reg;
    instr_next  = instr_reg;
    out_pc_next = out_pc_reg;

    // A redirect wins over everything: any ack this cycle belongs to the old
    // stream and is dropped. A concurrent valid/ready transfer still happens.
    if (in_pc_sel) begin
      pc_next    = in_target;
      state_next = FETCH;
      req_next   = 1'b1;
      valid_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = FETCH;
          req_next   = 1'b1;
        end
        FETCH: begin
          if (in_imem_ack) begin
            instr_next  = in_imem_data;
            out_pc_next = pc_reg;
            pc_next     = pc_reg + PC_ONE;
            valid_next  = 1'b1;
            req_next    = 1'b0;
            state_next  = HOLD;
          end
        end
        HOLD: begin
          // Acks arriving here have no request behind them and are ignored.
          if (in_ready) begin
            valid_next = 1'b0;
            req_next   = 1'b1;
            state_next = FETCH;
          end
        end
        default: begin
          state_next = IDLE;
          req_next   = 1'b0;
          valid_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      req_reg    <= 1'b0;
      valid_reg  <= 1'b0;
      instr_reg  <= '0;
      out_pc_reg <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      req_reg    <= req_next;
      valid_reg  <= valid_next;
      instr_reg  <= instr_next;
      out_pc_reg <= out_pc_next;
    end
  end

  assign out_imem_req  = req_reg;
  assign out_imem_addr = pc_reg;
  assign out_valid     = valid_reg;
  assign out_instr     = instr_reg;
  assign out_pc        = out_pc_reg;

endmodule
